// File: rtl/riscv.sv
// Single-cycle RV32I-subset core with word-addressed instruction and data memories.
// Latency: one instruction fetched, executed and retired per clk; memory reads are combinational.
// Backpressure: none; the core never stalls and has no flow-controlled interfaces.
// Ports: clk (single clock), rst_n (synchronous reset, ACTIVE HIGH despite the name).
// Observation is hierarchical: Instr_Mem.mem, Reg.regfile, Data_Mem.mem, pc_q.

// Instruction ROM: combinational word read, out-of-range fetches return NOP.
// Latency: zero cycles (combinational).
// Backpressure: none.
// Ports: widx_i word index (PC[31:2]), instr_o fetched instruction.
module riscv_imem #(
  parameter int DEPTH = 256
) (
  input  logic [29:0] widx_i,
  output logic [31:0] instr_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [0:DEPTH-1];

  assign instr_o = (widx_i < 30'(DEPTH)) ? mem[widx_i[AW-1:0]] : 32'h0000_0013;
endmodule

// Data RAM: combinational read, write on rising clk; out-of-range reads 0, writes dropped.
// Latency: read zero cycles, write visible after the clk edge.
// Backpressure: none.
// Ports: clk_i, we_i write enable, widx_i word index, wdata_i, rdata_o.
module riscv_dmem #(
  parameter int DEPTH = 256
) (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [29:0] widx_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0] mem [0:DEPTH-1];
  logic        in_range;

  assign in_range = (widx_i < 30'(DEPTH));
  assign rdata_o  = in_range ? mem[widx_i[AW-1:0]] : '0;

  always_ff @(posedge clk_i) begin
    if (we_i && in_range) begin
      mem[widx_i[AW-1:0]] <= wdata_i;
    end
  end
endmodule

// 32x32 register file, two combinational read ports, one write port; x0 reads 0.
// Latency: write visible after the clk edge, so same-cycle read sees the old value.
// Backpressure: none.
// Ports: clk_i, rst_i (sync, active high, clears all entries), we_i/waddr_i/wdata_i, raddr*_i/rdata*_o.
module riscv_regfile (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr1_i,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata1_o,
  output logic [31:0] rdata2_o
);
  logic [31:0] regfile [0:31];

  assign rdata1_o = (raddr1_i == 5'd0) ? '0 : regfile[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? '0 : regfile[raddr2_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 32; i++) begin
        regfile[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      regfile[waddr_i] <= wdata_i;
    end
  end
endmodule

module riscv #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256
) (
  input  logic clk,
  input  logic rst_n
);
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr, rs1_val, rs2_val, dmem_rdata, mem_addr, rd_wdata;
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        rd_we, dmem_we;
  logic        unused_addr_bits;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};

  // Loads and stores are word accesses; the byte offset is dropped.
  assign mem_addr         = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign unused_addr_bits = ^mem_addr[1:0];

  // alt selects sub (funct3 000) or sra (funct3 101).
  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? (a - b) : (a + b);
      3'b001:  return a << b[4:0];
      3'b010:  return {31'b0, $signed(a) < $signed(b)};
      3'b011:  return {31'b0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic br_taken(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] f3);
    case (f3)
      3'b000:  return a == b;
      3'b001:  return a != b;
      3'b100:  return $signed(a) < $signed(b);
      3'b101:  return $signed(a) >= $signed(b);
      3'b110:  return a < b;
      3'b111:  return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  riscv_imem #(.DEPTH(IMEM_DEPTH)) Instr_Mem (
    .widx_i (pc_q[31:2]),
    .instr_o(instr)
  );

  riscv_regfile Reg (
    .clk_i   (clk),
    .rst_i   (rst_n),
    .we_i    (rd_we),
    .waddr_i (rd),
    .wdata_i (rd_wdata),
    .raddr1_i(rs1),
    .raddr2_i(rs2),
    .rdata1_o(rs1_val),
    .rdata2_o(rs2_val)
  );

  riscv_dmem #(.DEPTH(DMEM_DEPTH)) Data_Mem (
    .clk_i  (clk),
    .we_i   (dmem_we),
    .widx_i (mem_addr[31:2]),
    .wdata_i(rs2_val),
    .rdata_o(dmem_rdata)
  );

  // Unlisted opcodes fall through the defaults: no writes, PC+4.
  always_comb begin
    pc_d     = pc_q + 32'd4;
    rd_we    = 1'b0;
    rd_wdata = '0;
    dmem_we  = 1'b0;
    case (opcode)
      OP_REG: begin
        rd_we    = 1'b1;
        rd_wdata = alu(rs1_val, rs2_val, funct3, instr[30]);
      end
      OP_IMM: begin
        rd_we    = 1'b1;
        // instr[30] is part of the immediate for addi; only srai uses it as a selector.
        rd_wdata = alu(rs1_val, imm_i, funct3, (funct3 == 3'b101) && instr[30]);
      end
      OP_LOAD: begin
        rd_we    = 1'b1;
        rd_wdata = dmem_rdata;
      end
      OP_STORE: begin
        dmem_we = ~rst_n;
      end
      OP_BRANCH: begin
        if (br_taken(rs1_val, rs2_val, funct3)) begin
          pc_d = pc_q + imm_b;
        end
      end
      OP_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + 32'd4;
        pc_d     = pc_q + imm_j;
      end
      OP_JALR: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + 32'd4;
        pc_d     = (rs1_val + imm_i) & ~32'd1;
      end
      OP_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OP_AUIPC: begin
        rd_we    = 1'b1;
        rd_wdata = pc_q + imm_u;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end
endmodule

// File: tb/tb_riscv.sv
module tb_riscv;
  localparam int IM = 256;
  localparam int DM = 256;
  localparam logic [6:0] OPI = 7'h13;

  logic clk;
  logic rst_n;
  logic chk_en;
  int   n_checks;
  int   n_fail;

  logic [31:0] prog [$];
  logic [31:0] m_imem [IM];
  logic [31:0] m_dmem [DM];
  logic [31:0] m_reg  [32];
  logic [31:0] m_pc;

  riscv #(.IMEM_DEPTH(IM), .DMEM_DEPTH(DM)) dut (
    .clk  (clk),
    .rst_n(rst_n)
  );

  always #5 clk = ~clk;

  // Instruction encoders
  function automatic logic [31:0] enc_i(input int imm, input int rs1, input int f3,
                                        input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm;
    return {v[11:0], 5'(rs1), 3'(f3), 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, input int rs2, input int rs1,
                                        input int f3, input int rd);
    return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [31:0] v;
    v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), 3'd2, v[4:0], 7'h23};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] v;
    v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), 3'(f3), v[4:1], v[11], 7'h63};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [31:0] v;
    v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'h6F};
  endfunction

  function automatic logic [31:0] enc_u(input int imm20, input int rd, input logic [6:0] op);
    logic [31:0] v;
    v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  // Instruction-set model: interprets each instruction word directly.
  task automatic model_step();
    logic [31:0] ins, a, b, res, nxt, ii, si, bi, ji, ui, ea;
    logic [29:0] wi;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic        wr, tk;
    int          w;
    if (rst_n) begin
      m_pc = '0;
      for (int r = 0; r < 32; r++) m_reg[r] = '0;
      return;
    end
    w   = int'(m_pc >> 2);
    ins = (w < IM) ? m_imem[w] : 32'h13;
    op  = ins[6:0];
    rd  = ins[11:7];
    f3  = ins[14:12];
    f7  = ins[31:25];
    a   = m_reg[ins[19:15]];
    b   = m_reg[ins[24:20]];
    ii  = 32'($signed(ins) >>> 20);
    si  = 32'($signed({ins[31:25], ins[11:7], 20'b0}) >>> 20);
    bi  = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0, 19'b0}) >>> 19);
    ji  = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0, 11'b0}) >>> 11);
    ui  = {ins[31:12], 12'b0};
    nxt = m_pc + 4;
    wr  = 1'b0;
    res = '0;
    case (op)
      7'h33: begin
        wr = 1'b1;
        case ({f7, f3})
          {7'h00, 3'd0}: res = a + b;
          {7'h20, 3'd0}: res = a - b;
          {7'h00, 3'd1}: res = a << b[4:0];
          {7'h00, 3'd2}: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
          {7'h00, 3'd3}: res = (a < b) ? 32'd1 : 32'd0;
          {7'h00, 3'd4}: res = a ^ b;
          {7'h00, 3'd5}: res = a >> b[4:0];
          {7'h20, 3'd5}: res = 32'($signed(a) >>> b[4:0]);
          {7'h00, 3'd6}: res = a | b;
          {7'h00, 3'd7}: res = a & b;
          default: wr = 1'b0;
        endcase
      end
      7'h13: begin
        wr = 1'b1;
        case (f3)
          3'd0: res = a + ii;
          3'd1: res = a << ii[4:0];
          3'd2: res = ($signed(a) < $signed(ii)) ? 32'd1 : 32'd0;
          3'd3: res = (a < ii) ? 32'd1 : 32'd0;
          3'd4: res = a ^ ii;
          3'd5: res = ins[30] ? 32'($signed(a) >>> ii[4:0]) : (a >> ii[4:0]);
          3'd6: res = a | ii;
          default: res = a & ii;
        endcase
      end
      7'h03: begin
        wr  = 1'b1;
        ea  = a + ii;
        wi  = ea[31:2];
        res = (wi < 30'(DM)) ? m_dmem[wi[7:0]] : 32'd0;
      end
      7'h23: begin
        ea = a + si;
        wi = ea[31:2];
        if (wi < 30'(DM)) m_dmem[wi[7:0]] = b;
      end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) nxt = m_pc + bi;
      end
      7'h6F: begin wr = 1'b1; res = m_pc + 4; nxt = m_pc + ji; end
      7'h67: begin wr = 1'b1; res = m_pc + 4; nxt = (a + ii) & ~32'd1; end
      7'h37: begin wr = 1'b1; res = ui; end
      7'h17: begin wr = 1'b1; res = m_pc + ui; end
      default: ;
    endcase
    if (wr && rd != 5'd0) m_reg[rd] = res;
    m_pc = nxt;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      model_step();
    end
  endtask

  task automatic reset_and_load();
    rst_n = 1'b1;
    run(2);
    for (int i = 0; i < IM; i++) begin
      m_imem[i] = (i < prog.size()) ? prog[i] : 32'h13;
      dut.Instr_Mem.mem[i] = m_imem[i];
    end
    chk_en = 1'b1;
    rst_n  = 1'b0;
  endtask

  // Hand-computed expectation, applied to both DUT and model.
  task automatic lit(input string name, input int r, input logic [31:0] exp);
    check({"dut_", name}, r, dut.Reg.regfile[r], exp);
    check({"model_", name}, r, m_reg[r], exp);
  endtask

  // Cycle-by-cycle comparison of architectural state against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", 0, dut.pc_q, m_pc);
      for (int r = 0; r < 32; r++) check("x", r, dut.Reg.regfile[r], m_reg[r]);
      for (int d = 0; d < DM; d++) check("dmem", d, dut.Data_Mem.mem[d], m_dmem[d]);
    end
  end

  initial begin
    clk      = 1'b0;
    rst_n    = 1'b1;
    chk_en   = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    m_pc     = '0;
    for (int d = 0; d < DM; d++) begin
      m_dmem[d] = '0;
      dut.Data_Mem.mem[d] = '0;
    end

    // Arithmetic, plus reset state
    prog = '{enc_i(5, 0, 0, 1, OPI), enc_i(7, 0, 0, 2, OPI),
             enc_r(0, 2, 1, 0, 3), enc_r('h20, 1, 2, 0, 4)};
    reset_and_load();
    check("reset_pc", 0, dut.pc_q, 32'd0);
    for (int r = 0; r < 32; r++) check("reset_x", r, dut.Reg.regfile[r], 32'd0);
    run(10);
    lit("x1", 1, 32'd5);
    lit("x2", 2, 32'd7);
    lit("x3", 3, 32'd12);
    lit("x4", 4, 32'd2);

    // x0 protection
    prog = '{enc_i(9, 0, 0, 0, OPI), enc_i(-1, 0, 0, 5, OPI)};
    reset_and_load();
    run(5);
    lit("x0", 0, 32'd0);
    lit("x5", 5, 32'hFFFF_FFFF);

    // Memory round trip
    prog = '{enc_i('h55, 0, 0, 1, OPI), enc_s(8, 1, 0), enc_i(8, 0, 2, 6, 7'h03)};
    reset_and_load();
    run(6);
    lit("x6", 6, 32'h55);
    check("dmem2", 2, dut.Data_Mem.mem[2], 32'h55);

    // Taken branch
    prog = '{enc_i(1, 0, 0, 1, OPI), enc_b(8, 1, 1, 0),
             enc_i(3, 0, 0, 7, OPI), enc_i(4, 0, 0, 8, OPI)};
    reset_and_load();
    run(6);
    lit("x7", 7, 32'd0);
    lit("x8", 8, 32'd4);

    // jal and lui
    prog = '{enc_j(8, 1), enc_i(1, 0, 0, 9, OPI), enc_u('h12345, 10, 7'h37)};
    reset_and_load();
    run(6);
    lit("x1", 1, 32'd4);
    lit("x9", 9, 32'd0);
    lit("x10", 10, 32'h1234_5000);

    // Shifts, compares, logic, auipc, all branch kinds, jalr, unsupported opcode,
    // out-of-range data access and fetch past the end of instruction memory.
    prog = '{enc_i(-8, 0, 0, 1, OPI), enc_i('h401, 1, 5, 2, OPI), enc_i(28, 1, 5, 3, OPI),
             enc_r(0, 0, 1, 2, 4), enc_r(0, 0, 1, 3, 5), enc_u(1, 6, 7'h17),
             enc_i(1, 1, 0, 1, OPI), enc_r(0, 3, 1, 4, 7), enc_r(0, 3, 3, 1, 8),
             enc_r('h20, 3, 1, 5, 9), enc_u(1, 11, 7'h37), enc_s(0, 3, 11),
             enc_i(0, 11, 2, 12, 7'h03), enc_b(8, 0, 1, 4), enc_i(1, 0, 0, 13, OPI),
             enc_b(8, 0, 1, 7), enc_i(2, 0, 0, 13, OPI), enc_b(8, 0, 1, 6),
             enc_b(8, 0, 1, 5), enc_b(8, 0, 0, 1), 32'h0000_077F,
             enc_i(100, 0, 0, 15, OPI), enc_i(1, 15, 0, 16, 7'h67),
             enc_i(1, 0, 0, 17, OPI), enc_i(2, 0, 0, 17, OPI),
             enc_i('h30, 3, 6, 18, OPI), enc_i('hF0, 1, 7, 19, OPI),
             enc_r(0, 3, 1, 7, 20), enc_r(0, 3, 8, 6, 21),
             enc_i(-6, 1, 2, 23, OPI), enc_i(-6, 1, 3, 24, OPI),
             enc_i(0, 11, 0, 0, 7'h67)};
    reset_and_load();
    run(32);
    lit("x1", 1, 32'hFFFF_FFF9);
    lit("x2", 2, 32'hFFFF_FFFC);
    lit("x3", 3, 32'h0000_000F);
    lit("x4", 4, 32'd1);
    lit("x5", 5, 32'd0);
    lit("x6", 6, 32'h0000_1014);
    lit("x7", 7, 32'hFFFF_FFF6);
    lit("x8", 8, 32'h0007_8000);
    lit("x9", 9, 32'hFFFF_FFFF);
    lit("x12", 12, 32'd0);
    lit("x13", 13, 32'd0);
    lit("x14", 14, 32'd0);
    lit("x16", 16, 32'd92);
    lit("x17", 17, 32'd0);
    lit("x18", 18, 32'h3F);
    lit("x19", 19, 32'hF0);
    lit("x20", 20, 32'd9);
    lit("x21", 21, 32'h0007_800F);
    lit("x23", 23, 32'd1);
    lit("x24", 24, 32'd1);
    check("dut_pc_oob", 0, dut.pc_q, 32'h0000_1010);
    check("model_pc_oob", 0, m_pc, 32'h0000_1010);

    // Reset mid-program, then re-execution from word 0
    prog = '{enc_i(5, 0, 0, 1, OPI), enc_i(7, 0, 0, 2, OPI),
             enc_r(0, 2, 1, 0, 3), enc_r('h20, 1, 2, 0, 4)};
    reset_and_load();
    run(3);
    lit("x3_pre", 3, 32'd12);
    rst_n = 1'b1;
    run(2);
    check("midrst_pc", 0, dut.pc_q, 32'd0);
    for (int r = 0; r < 32; r++) check("midrst_x", r, dut.Reg.regfile[r], 32'd0);
    rst_n = 1'b0;
    run(10);
    lit("x3_post", 3, 32'd12);
    lit("x4_post", 4, 32'd2);

    @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/riscv.md
RISCV -- requirements
Module: riscv

Interface
REQ-001 The block SHALL have parameter IMEM_DEPTH, default 256, meaning the number of 32-bit words in instruction memory.
REQ-002 The block SHALL have parameter DMEM_DEPTH, default 256, meaning the number of 32-bit words in data memory.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, a synchronous active-high reset (1 = reset); the name is kept as the codebase has it, and the polarity is high regardless of the suffix.
REQ-005 The block SHALL have no other ports; all observation is hierarchical.
REQ-006 The instance named Instr_Mem SHALL hold array mem[0:IMEM_DEPTH-1] of 32 bits, word-indexed, loadable by $readmemh from the testbench.
REQ-007 The instance named Reg SHALL hold array regfile[0:31] of 32 bits, readable and dumpable by $writememh.

Function
REQ-008 The core SHALL be a single-cycle RV32I subset: one instruction fetched, decoded, executed and retired per clock.
REQ-009 Instruction fetch SHALL be a combinational read of mem[PC[31:2]].
REQ-010 Fetch from a word index at or beyond IMEM_DEPTH SHALL return 0x00000013 (NOP).
REQ-011 The supported R-type set (opcode 0110011) SHALL be add, sub, sll, slt, sltu, xor, srl, sra, or, and.
REQ-012 The supported I-type ALU set (opcode 0010011) SHALL be addi, slti, sltiu, xori, ori, andi, slli, srli, srai.
REQ-013 Shift amounts SHALL use rs2[4:0] or imm[4:0].
REQ-014 The load lw (0000011) and store sw (0100011) SHALL access a word-addressed data memory (DMEM_DEPTH words) at index (rs1+imm)[31:2]; the low two address bits SHALL be ignored.
REQ-015 The data memory read SHALL be combinational, and the data memory write SHALL occur on the rising clk edge.
REQ-016 The branch set (1100011) SHALL be beq, bne, blt, bge, bltu, bgeu; when the branch is taken, next PC = PC + B-immediate.
REQ-017 The jump jal SHALL write PC+4 to rd and set next PC = PC + J-immediate.
REQ-018 The jump jalr SHALL write PC+4 to rd and set next PC = (rs1+imm) & ~1.
REQ-019 The U-type instructions SHALL be lui (rd = imm<<12) and auipc (rd = PC + imm<<12).
REQ-020 All immediates SHALL be sign-extended to 32 bits; arithmetic SHALL wrap modulo 2^32 with no overflow trap.
REQ-021 Otherwise next PC SHALL equal PC+4.
REQ-022 Register read SHALL be combinational, and register write SHALL occur on the rising clk edge.
REQ-023 Writes to x0 SHALL be discarded, and x0 SHALL always read 0.
REQ-024 When an instruction reads and writes the same register in one cycle, it SHALL read the old value.
REQ-025 Any unsupported opcode SHALL execute as NOP: no register or memory write, next PC = PC+4.
REQ-026 There SHALL be no pipeline, no hazards and no stalls; the latency of every instruction SHALL be exactly one cycle.

Reset
REQ-027 While rst_n=1 at a rising edge, PC SHALL become 0 and all regfile entries SHALL become 0.
REQ-028 While rst_n=1, no data memory write SHALL occur.
REQ-029 The data memory and instruction memory SHALL NOT be cleared by reset.
REQ-030 The first instruction executed SHALL be mem[0], retiring at the first rising edge after rst_n returns to 0.
REQ-031 Reset asserted mid-program SHALL abort execution at that edge and apply REQ-027.

Verification
REQ-032 The bench SHALL cover arithmetic: mem = {addi x1,x0,5; addi x2,x0,7; add x3,x1,x2; sub x4,x2,x1}, 10 cycles after reset -> x3=12, x4=2, x1=5, x2=7.
REQ-033 The bench SHALL cover x0 protection: addi x0,x0,9; addi x5,x0,-1 -> x0=0, x5=0xFFFFFFFF.
REQ-034 The bench SHALL cover memory round trip: addi x1,x0,0x55; sw x1,8(x0); lw x6,8(x0) -> x6=0x55.
REQ-035 The bench SHALL cover a taken branch: addi x1,x0,1; beq x1,x1,+8; addi x7,x0,3; addi x8,x0,4 -> x7=0, x8=4.
REQ-036 The bench SHALL cover jal and lui: jal x1,+8; addi x9,x0,1; lui x10,0x12345 -> x1=4, x9=0, x10=0x12345000.
REQ-037 The bench SHALL cover reset: apply rst_n=1 for 2 cycles mid-run -> all regfile = 0, PC = 0, then re-execution from mem[0].
